csr_access_ctrl: RTL and testbench

//  Two-port CSR access controller. Round-robin arbitrates between the core port (c_*) and the debug port (d_*).

---
 rtl/csr_access_ctrl_if.sv | 14 +
 rtl/csr_access_ctrl.sv | 128 ++++++++++++
 tb/tb_csr_access_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/csr_access_ctrl_if.sv
// One CSR access port: a held request with operands, answered by a one-cycle ack
// that carries the old CSR value and an error flag.
interface csr_access_ctrl_if;
  logic        req;
  logic [1:0]  op;
  logic [11:0] adr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, op, adr, wdata, input ack, rdata, err);
  modport slave  (input req, op, adr, wdata, output ack, rdata, err);
endinterface

// File: rtl/csr_access_ctrl.sv
// Two-port round-robin CSR access controller.
// It performs read-modify-write on mcycle, minstret, mscratch and mtvec.
module csr_access_ctrl #(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0100
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               instret_i,
  csr_access_ctrl_if.slave   c_if,
  csr_access_ctrl_if.slave   d_if,
  output logic [31:0]        mtvec_o
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t      r_state, w_next;
  logic        r_port, r_rr;
  logic [1:0]  r_op;
  logic [11:0] r_adr;
  logic [31:0] r_wdata, r_rd;
  logic [63:0] r_mcycle, r_minstret;
  logic [31:0] r_mscratch, r_mtvec;

  logic        w_grant, w_gnt_port;
  logic [31:0] w_rd_val, w_new;
  logic        w_mapped, w_ro, w_wr_try, w_we, w_err;

  // Arbitration: a tie goes to the port named by the round-robin pointer
  always_comb begin
    w_next     = r_state;
    w_grant    = 1'b0;
    w_gnt_port = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (c_if.req || d_if.req) begin
          w_grant    = 1'b1;
          w_gnt_port = (c_if.req && d_if.req) ? r_rr : d_if.req;
          w_next     = S_READ;
        end
      end
      S_READ:  w_next = S_WRITE;
      S_WRITE: w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd_val = 32'h0;
    w_mapped = 1'b1;
    w_ro     = 1'b0;
    case (r_adr)
      12'hC00: begin w_rd_val = r_mcycle[31:0];    w_ro = 1'b1; end
      12'hC80: begin w_rd_val = r_mcycle[63:32];   w_ro = 1'b1; end
      12'hC02: begin w_rd_val = r_minstret[31:0];  w_ro = 1'b1; end
      12'hC82: begin w_rd_val = r_minstret[63:32]; w_ro = 1'b1; end
      12'hB00: w_rd_val = r_mcycle[31:0];
      12'hB80: w_rd_val = r_mcycle[63:32];
      12'hB02: w_rd_val = r_minstret[31:0];
      12'hB82: w_rd_val = r_minstret[63:32];
      12'h340: w_rd_val = r_mscratch;
      12'h305: w_rd_val = r_mtvec;
      default: w_mapped = 1'b0;
    endcase
  end

  // RS/RC with a zero operand is a pure read, so it stays legal on read-only CSRs
  always_comb begin
    w_wr_try = (r_op == 2'b01) || (r_op[1] && (r_wdata != 32'h0));
    case (r_op)
      2'b01:   w_new = r_wdata;
      2'b10:   w_new = r_rd | r_wdata;
      2'b11:   w_new = r_rd & ~r_wdata;
      default: w_new = r_rd;
    endcase
    w_we  = (r_state == S_WRITE) && w_wr_try && w_mapped && !w_ro;
    w_err = !w_mapped || (w_wr_try && w_ro);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_port  <= 1'b0;
      r_rr    <= 1'b0;
      r_op    <= 2'b00;
      r_adr   <= 12'h0;
      r_wdata <= 32'h0;
      r_rd    <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_port  <= w_gnt_port;
        r_rr    <= ~w_gnt_port;
        r_op    <= w_gnt_port ? d_if.op    : c_if.op;
        r_adr   <= w_gnt_port ? d_if.adr   : c_if.adr;
        r_wdata <= w_gnt_port ? d_if.wdata : c_if.wdata;
      end
      if (r_state == S_READ) r_rd <= w_rd_val;
    end
  end

  // A CSR write to either counter half suppresses that counter's increment
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mcycle   <= 64'h0;
      r_minstret <= 64'h0;
      r_mscratch <= 32'h0;
      r_mtvec    <= MTVEC_RST;
    end else begin
      if (w_we && r_adr == 12'hB00)      r_mcycle <= {r_mcycle[63:32], w_new};
      else if (w_we && r_adr == 12'hB80) r_mcycle <= {w_new, r_mcycle[31:0]};
      else                               r_mcycle <= r_mcycle + 64'd1;
      if (w_we && r_adr == 12'hB02)      r_minstret <= {r_minstret[63:32], w_new};
      else if (w_we && r_adr == 12'hB82) r_minstret <= {w_new, r_minstret[31:0]};
      else if (instret_i)                r_minstret <= r_minstret + 64'd1;
      if (w_we && r_adr == 12'h340) r_mscratch <= w_new;
      if (w_we && r_adr == 12'h305) r_mtvec    <= w_new & 32'hFFFF_FFFC;
    end
  end

  assign c_if.ack   = (r_state == S_DONE) && !r_port;
  assign d_if.ack   = (r_state == S_DONE) &&  r_port;
  assign c_if.rdata = c_if.ack ? r_rd : 32'h0;
  assign d_if.rdata = d_if.ack ? r_rd : 32'h0;
  assign c_if.err   = c_if.ack && w_err;
  assign d_if.err   = d_if.ack && w_err;
  assign mtvec_o    = r_mtvec;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed bench for csr_access_ctrl: a vector table of single accesses plus
// hand sequences for latency, arbitration ties, counter writes and mid-access reset.
module tb_csr_access_ctrl;
  logic        clk_i = 1'b0, rst_i = 1'b1, instret_i = 1'b0;
  logic [31:0] mtvec_o;

  csr_access_ctrl_if c_if();
  csr_access_ctrl_if d_if();

  csr_access_ctrl #(.MTVEC_RST(32'h0000_0100)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instret_i(instret_i),
    .c_if(c_if), .d_if(d_if), .mtvec_o(mtvec_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, failures = 0;

  typedef struct {
    bit          dbg;
    logic [1:0]  op;
    logic [11:0] adr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [31:0] exp_mtvec;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input bit dbg, input bit req, input logic [1:0] op,
                       input logic [11:0] adr, input logic [31:0] wd);
    if (dbg) begin d_if.req = req; d_if.op = op; d_if.adr = adr; d_if.wdata = wd; end
    else     begin c_if.req = req; c_if.op = op; c_if.adr = adr; c_if.wdata = wd; end
  endtask

  // Request, wait (bounded) for the ack, drop the request in the ack cycle
  task automatic access(input bit dbg, input logic [1:0] op, input logic [11:0] adr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic err);
    bit ok = 0;
    rd = 32'h0; err = 1'b0;
    drive(dbg, 1'b1, op, adr, wd);
    for (int i = 0; i < 12 && !ok; i++) begin
      @(posedge clk_i); #1;
      if (dbg ? d_if.ack : c_if.ack) begin
        ok  = 1;
        rd  = dbg ? d_if.rdata : c_if.rdata;
        err = dbg ? d_if.err   : c_if.err;
      end
    end
    drive(dbg, 1'b0, op, adr, wd);
    chk("ack_timeout", {31'h0, ok}, 32'h1);
  endtask

  task automatic rst_pulse();
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    bit          order[2];
    int          n;
    bit          dual;

    vt[0]  = '{0, 2'b01, 12'h340, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 32'h100};
    vt[1]  = '{0, 2'b10, 12'h340, 32'h0000_00F0, 32'hDEAD_BEEF, 1'b0, 32'h100};
    vt[2]  = '{0, 2'b00, 12'h340, 32'h0,         32'hDEAD_BEFF, 1'b0, 32'h100};
    vt[3]  = '{0, 2'b11, 12'h340, 32'h0000_000F, 32'hDEAD_BEFF, 1'b0, 32'h100};
    vt[4]  = '{1, 2'b00, 12'h340, 32'h0,         32'hDEAD_BEF0, 1'b0, 32'h100};
    vt[5]  = '{0, 2'b01, 12'hC80, 32'h1,         32'h0,         1'b1, 32'h100};
    vt[6]  = '{0, 2'b00, 12'hC80, 32'h0,         32'h0,         1'b0, 32'h100};
    vt[7]  = '{0, 2'b10, 12'hC80, 32'h0,         32'h0,         1'b0, 32'h100};
    vt[8]  = '{0, 2'b00, 12'h7FF, 32'h0,         32'h0,         1'b1, 32'h100};
    vt[9]  = '{1, 2'b10, 12'h7FF, 32'h0,         32'h0,         1'b1, 32'h100};
    vt[10] = '{0, 2'b01, 12'h305, 32'h0000_0203, 32'h0000_0100, 1'b0, 32'h200};
    vt[11] = '{0, 2'b00, 12'h305, 32'h0,         32'h0000_0200, 1'b0, 32'h200};
    vt[12] = '{1, 2'b11, 12'h305, 32'h0000_0200, 32'h0000_0200, 1'b0, 32'h0};
    vt[13] = '{1, 2'b00, 12'h305, 32'h0,         32'h0,         1'b0, 32'h0};

    drive(0, 1'b0, 2'b00, 12'h0, 32'h0);
    drive(1, 1'b0, 2'b00, 12'h0, 32'h0);

    // Reset state
    repeat (3) @(posedge clk_i); #1;
    chk("rst_c_ack", {31'h0, c_if.ack}, 32'h0);
    chk("rst_d_ack", {31'h0, d_if.ack}, 32'h0);
    chk("rst_c_rdata", c_if.rdata, 32'h0);
    chk("rst_c_err", {31'h0, c_if.err}, 32'h0);
    chk("rst_mtvec", mtvec_o, 32'h100);
    rst_i = 1'b0;

    // Latency: mcycle=12 in the sampling cycle, 13 in READ, ack exactly 3 edges later
    repeat (12) @(posedge clk_i); #1;
    drive(0, 1'b1, 2'b00, 12'hC00, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk_i); #1;
      chk($sformatf("lat_c_ack_n%0d", i), {31'h0, c_if.ack}, (i == 3) ? 32'h1 : 32'h0);
      chk($sformatf("lat_d_ack_n%0d", i), {31'h0, d_if.ack}, 32'h0);
    end
    chk("lat_rdata", c_if.rdata, 32'd13);
    chk("lat_err", {31'h0, c_if.err}, 32'h0);
    drive(0, 1'b0, 2'b00, 12'hC00, 32'h0);
    @(posedge clk_i); #1;
    chk("lat_ack_drop", {31'h0, c_if.ack}, 32'h0);

    // Round-robin ties from reset: core, debug, then core again
    rst_pulse();
    dual = 0;
    for (int t = 0; t < 2; t++) begin
      n = 0;
      drive(0, 1'b1, 2'b00, 12'h340, 32'h0);
      drive(1, 1'b1, 2'b00, 12'h340, 32'h0);
      for (int i = 0; i < 20 && n < 2; i++) begin
        @(posedge clk_i); #1;
        if (c_if.ack && d_if.ack) dual = 1;
        if (c_if.ack)      begin order[n] = 0; n++; c_if.req = 1'b0; end
        else if (d_if.ack) begin order[n] = 1; n++; d_if.req = 1'b0; end
      end
      chk($sformatf("tie%0d_count", t), n, 2);
      chk($sformatf("tie%0d_first", t), {31'h0, order[0]}, 32'h0);
      chk($sformatf("tie%0d_second", t), {31'h0, order[1]}, 32'h1);
    end
    chk("tie_dual_ack", {31'h0, dual}, 32'h0);

    // Table of single accesses
    for (int k = 0; k < 14; k++) begin
      access(vt[k].dbg, vt[k].op, vt[k].adr, vt[k].wd, rd, err);
      chk($sformatf("vec%0d_rdata", k), rd, vt[k].exp_rd);
      chk($sformatf("vec%0d_err", k), {31'h0, err}, {31'h0, vt[k].exp_err});
      chk($sformatf("vec%0d_mtvec", k), mtvec_o, vt[k].exp_mtvec);
    end

    // mcycle lo write then carry: hi reaches 1 two cycles after the lo write
    access(0, 2'b01, 12'hB80, 32'h0, rd, err);
    access(0, 2'b01, 12'hB00, 32'hFFFF_FFFF, rd, err);
    access(0, 2'b00, 12'hB80, 32'h0, rd, err);
    chk("mcycle_hi_carry", rd, 32'h1);
    access(0, 2'b00, 12'hB00, 32'h0, rd, err);
    chk("mcycle_lo_after_wrap", rd, 32'd5);

    // minstret write wins over an instret pulse in the same cycle
    access(0, 2'b00, 12'hB02, 32'h0, rd, err);
    chk("minstret_initial", rd, 32'h0);
    @(posedge clk_i); #1;
    drive(0, 1'b1, 2'b01, 12'hB02, 32'd5);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    instret_i = 1'b1;
    @(posedge clk_i); #1;
    instret_i = 1'b0;
    chk("minstret_wr_ack", {31'h0, c_if.ack}, 32'h1);
    chk("minstret_wr_old", c_if.rdata, 32'h0);
    drive(0, 1'b0, 2'b01, 12'hB02, 32'd5);
    access(0, 2'b00, 12'hC02, 32'h0, rd, err);
    chk("minstret_write_wins", rd, 32'd5);
    instret_i = 1'b1;
    repeat (3) @(posedge clk_i); #1;
    instret_i = 1'b0;
    access(0, 2'b00, 12'hC02, 32'h0, rd, err);
    chk("minstret_incr", rd, 32'd8);
    chk("minstret_err", {31'h0, err}, 32'h0);

    // Reset during WRITE of an RW to mscratch: no write, no ack
    @(posedge clk_i); #1;
    drive(0, 1'b1, 2'b01, 12'h340, 32'h1111_1111);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    drive(0, 1'b0, 2'b01, 12'h340, 32'h1111_1111);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("midrst_no_ack%0d", i), {31'h0, c_if.ack}, 32'h0);
      @(posedge clk_i); #1;
    end
    chk("midrst_mtvec", mtvec_o, 32'h100);
    access(0, 2'b00, 12'h340, 32'h0, rd, err);
    chk("midrst_mscratch", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
